piso_tx: RTL

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-entry holding register so that back-to-back words leave with no idle gap.
// Optional even-parity bit after each word: define PISO_PARITY_EN.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  localparam bit HAS_PARITY = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  localparam bit HAS_PARITY = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
`ifdef PISO_PARITY_EN
  logic             par_bit;
`endif

  logic             transfer;
  logic             frame_end;
  logic             load_hold;
  logic             start;
  logic [WIDTH-1:0] start_word;
  logic [CW-1:0]    cnt_nxt;

  // Bit index counts positions in send order; map it onto the word here.
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
    if (MSB_FIRST != 0) return w[LAST_IDX - idx];
    else                return w[idx];
  endfunction

  assign din_ready = ~hold_full;
  assign busy      = (state != IDLE) || hold_full;
  assign transfer  = din_valid && din_ready;
  assign frame_end = sout_last;
  assign load_hold = transfer && (state != IDLE) && !frame_end;
  assign cnt_nxt   = cnt + CW'(1);

  // NOTE: every output of always_comb gets a default first, otherwise an uncovered path infers a latch.
  always_comb begin
    start      = 1'b0;
    start_word = din;
    if (state == IDLE) begin
      start = transfer;
    end else if (frame_end) begin
      if (hold_full) begin
        start      = 1'b1;
        start_word = hold;
      end else begin
        start = transfer;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      if (load_hold) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (frame_end && hold_full) begin
        hold_full <= 1'b0;
      end

      if (start) begin
        state      <= SHIFT;
        cnt        <= '0;
        shreg      <= start_word;
        sout       <= pick(start_word, '0);
        sout_valid <= 1'b1;
        sout_last  <= 1'b0;
`ifdef PISO_PARITY_EN
        par_bit    <= ^start_word;
`endif
      end else if (frame_end) begin
        state      <= IDLE;
        cnt        <= '0;
        sout       <= 1'b0;
        sout_valid <= 1'b0;
        sout_last  <= 1'b0;
      end else if (state == SHIFT) begin
`ifdef PISO_PARITY_EN
        if (cnt == LAST_IDX) begin
          state     <= PARITY;
          sout      <= par_bit;
          sout_last <= 1'b1;
        end else
`endif
        begin
          cnt       <= cnt_nxt;
          sout      <= pick(shreg, cnt_nxt);
          sout_last <= !HAS_PARITY && (cnt_nxt == LAST_IDX);
        end
      end
    end
  end

endmodule
